// File: rtl/botassium_mbox_pkg.sv
// Shared constants and elaboration helpers for the Nios/fabric mailbox RAM.
package botassium_mbox_pkg;

  localparam int unsigned COLL_CNT_W = 16;

  function automatic int unsigned be_w(input int unsigned data_w);
    return data_w / 8;
  endfunction

  // The top word of the array doubles as the doorbell register.
  function automatic int unsigned db_addr(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

  function automatic bit lat_legal(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/botassium_dpram_core.sv
// Byte-enabled true dual-port array with priority merge on same-word writes and
// one registered read port per side (read-before-write across ports).
module botassium_dpram_core
  import botassium_mbox_pkg::*;
#(
  parameter int unsigned DataW      = 32,
  parameter int unsigned AddrW      = 7,
  parameter bit          S1Priority = 1'b1,
  localparam int unsigned BeW       = be_w(DataW)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             a_we_i,
  input  logic             a_re_i,
  input  logic [AddrW-1:0] a_addr_i,
  input  logic [DataW-1:0] a_wdata_i,
  input  logic [BeW-1:0]   a_be_i,
  output logic [DataW-1:0] a_rdata_o,
  input  logic             b_we_i,
  input  logic             b_re_i,
  input  logic [AddrW-1:0] b_addr_i,
  input  logic [DataW-1:0] b_wdata_i,
  input  logic [BeW-1:0]   b_be_i,
  output logic [DataW-1:0] b_rdata_o
);

  localparam int unsigned Depth = 2 ** AddrW;

  logic [DataW-1:0] mem_q [Depth];
  logic [DataW-1:0] a_rdata_q, b_rdata_q;
  logic [BeW-1:0]   a_mask, b_mask;
  logic             same_word;

  // Lanes claimed by both ports on the same word go only to the priority side.
  always_comb begin
    same_word = a_we_i && b_we_i && (a_addr_i == b_addr_i);
    a_mask    = a_we_i ? a_be_i : '0;
    b_mask    = b_we_i ? b_be_i : '0;
    if (same_word) begin
      if (S1Priority) begin
        b_mask = b_mask & ~a_mask;
      end else begin
        a_mask = a_mask & ~b_mask;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned i = 0; i < BeW; i++) begin
      if (a_mask[i]) mem_q[a_addr_i][8*i +: 8] <= a_wdata_i[8*i +: 8];
      if (b_mask[i]) mem_q[b_addr_i][8*i +: 8] <= b_wdata_i[8*i +: 8];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (a_re_i) a_rdata_q <= mem_q[a_addr_i];
      if (b_re_i) b_rdata_q <= mem_q[b_addr_i];
    end
  end

  assign a_rdata_o = a_rdata_q;
  assign b_rdata_o = b_rdata_q;

endmodule

// File: rtl/botassium_mailbox_ram.sv
// Dual Avalon-MM mailbox RAM: read latency pipeline with per-port stall,
// doorbell interrupts between the two sides and a write-collision counter.
module botassium_mailbox_ram
  import botassium_mbox_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 7,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned S1_PRIORITY  = 1,
  localparam int unsigned BE_W        = be_w(DATA_W)
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_clken,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [BE_W-1:0]       s1_byteenable,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic                  s1_irq,
  input  logic [ADDR_W-1:0]     s2_address,
  input  logic                  s2_chipselect,
  input  logic                  s2_clken,
  input  logic                  s2_write,
  input  logic [DATA_W-1:0]     s2_writedata,
  input  logic [BE_W-1:0]       s2_byteenable,
  output logic [DATA_W-1:0]     s2_readdata,
  output logic                  s2_readdatavalid,
  output logic                  s2_irq,
  output logic [COLL_CNT_W-1:0] collision_cnt
);

  if (!lat_legal(READ_LATENCY)) begin : gen_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_W % 8 != 0) begin : gen_bad_width
    $error("DATA_W must be a multiple of 8");
  end

  localparam logic [ADDR_W-1:0] DbAddr = ADDR_W'(db_addr(ADDR_W));

  logic [1:0]            en, acc, wr, rd, db_set, db_clr;
  logic [ADDR_W-1:0]     addr [2];
  logic [BE_W-1:0]       be [2];
  logic [DATA_W-1:0]     core_rdata [2];
  logic [DATA_W-1:0]     data2_q [2];
  logic [1:0]            v1_q, v2_q;
  logic [1:0]            irq_q, irq_d;
  logic [COLL_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    en      = {s2_clken, s1_clken};
    acc     = {s2_chipselect, s1_chipselect} & en & {2{~reset_reset}};
    wr      = acc & {s2_write, s1_write};
    rd      = acc & ~{s2_write, s1_write};
    addr[0] = s1_address;
    addr[1] = s2_address;
    be[0]   = s1_byteenable;
    be[1]   = s2_byteenable;
  end

  botassium_dpram_core #(
    .DataW      (DATA_W),
    .AddrW      (ADDR_W),
    .S1Priority (S1_PRIORITY != 0)
  ) u_core (
    .clk_i     (clk_clk),
    .rst_i     (reset_reset),
    .a_we_i    (wr[0]),
    .a_re_i    (rd[0]),
    .a_addr_i  (s1_address),
    .a_wdata_i (s1_writedata),
    .a_be_i    (s1_byteenable),
    .a_rdata_o (core_rdata[0]),
    .b_we_i    (wr[1]),
    .b_re_i    (rd[1]),
    .b_addr_i  (s2_address),
    .b_wdata_i (s2_writedata),
    .b_be_i    (s2_byteenable),
    .b_rdata_o (core_rdata[1])
  );

  // A write into the opposite side's doorbell beats a same-cycle clearing read.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      db_set[p] = wr[1-p] && (addr[1-p] == DbAddr) && (|be[1-p]);
      db_clr[p] = rd[p] && (addr[p] == DbAddr);
      irq_d[p]  = db_set[p] || (irq_q[p] && !db_clr[p]);
    end
    cnt_d = cnt_q;
    if (wr[0] && wr[1] && (addr[0] == addr[1]) && (cnt_q != '1)) begin
      cnt_d = cnt_q + COLL_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      v1_q    <= '0;
      v2_q    <= '0;
      data2_q <= '{default: '0};
      irq_q   <= '0;
      cnt_q   <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (en[p]) begin
          v1_q[p] <= rd[p];
          v2_q[p] <= v1_q[p];
          if (v1_q[p]) data2_q[p] <= core_rdata[p];
        end
      end
      irq_q <= irq_d;
      cnt_q <= cnt_d;
    end
  end

  // Stalled ports hold their stages; the valid pulse is masked until clken returns.
  assign s1_readdata      = (READ_LATENCY == 2) ? data2_q[0] : core_rdata[0];
  assign s2_readdata      = (READ_LATENCY == 2) ? data2_q[1] : core_rdata[1];
  assign s1_readdatavalid = ((READ_LATENCY == 2) ? v2_q[0] : v1_q[0]) & s1_clken;
  assign s2_readdatavalid = ((READ_LATENCY == 2) ? v2_q[1] : v1_q[1]) & s2_clken;
  assign s1_irq           = irq_q[0];
  assign s2_irq           = irq_q[1];
  assign collision_cnt    = cnt_q;

endmodule

// File: tb/tb_botassium_mailbox_ram.sv
// Bench for the mailbox RAM: two builds (latency 1 / s1 priority, latency 2 / s2
// priority) share stimulus and are both checked against a transaction-level model.
module tb_botassium_mailbox_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cs [2];
  logic        ce [2];
  logic        we [2];
  logic [6:0]  ad [2];
  logic [31:0] wd [2];
  logic [3:0]  be [2];

  logic [31:0] o_rdata [2][2];
  logic        o_valid [2][2];
  logic        o_irq   [2][2];
  logic [15:0] o_cnt   [2];

  int n_err;
  int n_chk;
  bit chk_on;

  botassium_mailbox_ram #(
    .DATA_W(32), .ADDR_W(7), .READ_LATENCY(1), .S1_PRIORITY(1)
  ) u_a (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .s1_address       (ad[0]),
    .s1_chipselect    (cs[0]),
    .s1_clken         (ce[0]),
    .s1_write         (we[0]),
    .s1_writedata     (wd[0]),
    .s1_byteenable    (be[0]),
    .s1_readdata      (o_rdata[0][0]),
    .s1_readdatavalid (o_valid[0][0]),
    .s1_irq           (o_irq[0][0]),
    .s2_address       (ad[1]),
    .s2_chipselect    (cs[1]),
    .s2_clken         (ce[1]),
    .s2_write         (we[1]),
    .s2_writedata     (wd[1]),
    .s2_byteenable    (be[1]),
    .s2_readdata      (o_rdata[0][1]),
    .s2_readdatavalid (o_valid[0][1]),
    .s2_irq           (o_irq[0][1]),
    .collision_cnt    (o_cnt[0])
  );

  botassium_mailbox_ram #(
    .DATA_W(32), .ADDR_W(7), .READ_LATENCY(2), .S1_PRIORITY(0)
  ) u_b (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .s1_address       (ad[0]),
    .s1_chipselect    (cs[0]),
    .s1_clken         (ce[0]),
    .s1_write         (we[0]),
    .s1_writedata     (wd[0]),
    .s1_byteenable    (be[0]),
    .s1_readdata      (o_rdata[1][0]),
    .s1_readdatavalid (o_valid[1][0]),
    .s1_irq           (o_irq[1][0]),
    .s2_address       (ad[1]),
    .s2_chipselect    (cs[1]),
    .s2_clken         (ce[1]),
    .s2_write         (we[1]),
    .s2_writedata     (wd[1]),
    .s2_byteenable    (be[1]),
    .s2_readdata      (o_rdata[1][1]),
    .s2_readdatavalid (o_valid[1][1]),
    .s2_irq           (o_irq[1][1]),
    .collision_cnt    (o_cnt[1])
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  age;   // enabled edges seen since acceptance
  } pend_t;

  pend_t       pq [4][$];        // index 2*dut + port
  logic [31:0] mem_m  [2][128];
  logic [31:0] last_m [2][2];
  bit          irq_m  [2][2];
  int unsigned cnt_m  [2];

  bit    m_wr [2];
  bit    m_rd [2];
  bit    m_nirq [2];
  int    m_q;
  int    m_lo;
  pend_t m_e;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int p = 0; p < 2; p++) begin
          pq[2*d+p].delete();
          last_m[d][p] = '0;
          irq_m[d][p]  = 1'b0;
        end
        cnt_m[d] = 0;
      end else begin
        for (int p = 0; p < 2; p++) begin
          m_wr[p] = cs[p] && ce[p] && we[p];
          m_rd[p] = cs[p] && ce[p] && !we[p];
        end
        for (int p = 0; p < 2; p++) begin
          if (ce[p]) begin
            m_q = 2*d + p;
            for (int i = 0; i < pq[m_q].size(); i++) begin
              m_e = pq[m_q][i];
              m_e.age = m_e.age + 4'd1;
              pq[m_q][i] = m_e;
            end
            while (pq[m_q].size() > 0) begin
              m_e = pq[m_q][0];
              if (int'(m_e.age) > lat_of(d)) void'(pq[m_q].pop_front());
              else break;
            end
            if (m_rd[p]) begin
              m_e.data = mem_m[d][ad[p]];
              m_e.age  = 4'd1;
              pq[m_q].push_back(m_e);
            end
            for (int i = 0; i < pq[m_q].size(); i++) begin
              m_e = pq[m_q][i];
              if (int'(m_e.age) == lat_of(d)) last_m[d][p] = m_e.data;
            end
          end
        end
        for (int p = 0; p < 2; p++) begin
          if (m_wr[1-p] && ad[1-p] == 7'h7F && be[1-p] != 4'h0) m_nirq[p] = 1'b1;
          else if (m_rd[p] && ad[p] == 7'h7F) m_nirq[p] = 1'b0;
          else m_nirq[p] = irq_m[d][p];
        end
        irq_m[d][0] = m_nirq[0];
        irq_m[d][1] = m_nirq[1];
        if (m_wr[0] && m_wr[1] && ad[0] == ad[1] && cnt_m[d] < 65535) cnt_m[d]++;
        // Apply the losing port first so the winner's bytes land last.
        m_lo = (d == 0) ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
          for (int b = 0; b < 4; b++) begin
            if (m_wr[(k == 0) ? m_lo : 1-m_lo] && be[(k == 0) ? m_lo : 1-m_lo][b])
              mem_m[d][ad[(k == 0) ? m_lo : 1-m_lo]][8*b +: 8] =
                wd[(k == 0) ? m_lo : 1-m_lo][8*b +: 8];
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  bit c_ev;
  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 2; p++) begin
          c_ev = 1'b0;
          for (int i = 0; i < pq[2*d+p].size(); i++) begin
            if (int'(pq[2*d+p][i].age) == lat_of(d)) c_ev = ce[p];
          end
          check($sformatf("d%0d.s%0d.valid", d, p+1), 32'(o_valid[d][p]), 32'(c_ev));
          check($sformatf("d%0d.s%0d.rdata", d, p+1), o_rdata[d][p], last_m[d][p]);
          check($sformatf("d%0d.s%0d.irq", d, p+1), 32'(o_irq[d][p]), 32'(irq_m[d][p]));
        end
        check($sformatf("d%0d.cnt", d), 32'(o_cnt[d]), cnt_m[d]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_all();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; ce[p] = 1'b1; we[p] = 1'b0;
      ad[p] = '0;   wd[p] = '0;   be[p] = '0;
    end
  endtask

  task automatic acc(input int p, input bit w, input logic [6:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    cs[p] = 1'b1; ce[p] = 1'b1; we[p] = w; ad[p] = a; wd[p] = d; be[p] = b;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] t_cs;
  logic [9:0] t_ce;
  int         t_ad [10] = '{0, 1, 0, 0, 2, 3, 0, 0, 0, 0};

  task automatic apply_step(input int k);
    idle_all();
    cs[0] = t_cs[k];
    ce[0] = t_ce[k];
    ad[0] = 7'(t_ad[k]);
    if (k == 0) acc(1, 1'b0, 7'd1, '0, '0);
  endtask

  int n_pulse;
  int r;
  bit exp_v;

  initial begin
    n_err = 0; n_chk = 0; chk_on = 1'b0;
    for (int d = 0; d < 2; d++) for (int i = 0; i < 128; i++) mem_m[d][i] = '0;
    rst = 1'b1;
    idle_all();
    repeat (3) cyc();
    rst = 1'b0;
    chk_on = 1'b1;

    // Known contents everywhere, then a clean reset.
    for (int i = 0; i < 128; i++) begin
      acc(0, 1'b1, 7'(i), '0, 4'hF);
      cyc();
    end
    idle_all();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    @(negedge clk);
    check("reset.s1_rdata", o_rdata[0][0], 32'h0);
    check("reset.s2_irq", 32'(o_irq[0][1]), 32'h0);
    check("reset.cnt", 32'(o_cnt[0]), 32'h0);

    // Write on s1, read back on s2 one cycle later.
    acc(0, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF); cyc(); idle_all();
    acc(1, 1'b0, 7'd5, '0, '0); cyc(); idle_all();
    @(negedge clk);
    check("rd5.valid", 32'(o_valid[0][1]), 32'h1);
    check("rd5.data", o_rdata[0][1], 32'hDEADBEEF);

    // Byte-lane collision on word 3.
    acc(0, 1'b1, 7'd3, 32'h11111111, 4'b0011);
    acc(1, 1'b1, 7'd3, 32'h22222222, 4'b0110);
    cyc(); idle_all();
    acc(0, 1'b0, 7'd3, '0, '0); cyc(); idle_all();
    @(negedge clk);
    check("coll.s1pri", o_rdata[0][0], 32'h00221111);
    check("coll.cnt", 32'(o_cnt[0]), 32'h1);
    cyc();
    @(negedge clk);
    check("coll.s2pri", o_rdata[1][0], 32'h00222211);

    // Doorbell s1 -> s2, clear by read, set beats clear.
    acc(0, 1'b1, 7'h7F, 32'h1, 4'hF); cyc(); idle_all();
    @(negedge clk);
    check("db.s2_set", 32'(o_irq[0][1]), 32'h1);
    check("db.s1_quiet", 32'(o_irq[0][0]), 32'h0);
    acc(1, 1'b0, 7'h7F, '0, '0); cyc(); idle_all();
    @(negedge clk);
    check("db.s2_clr", 32'(o_irq[0][1]), 32'h0);
    acc(0, 1'b1, 7'h7F, 32'h2, 4'hF); cyc();
    acc(1, 1'b0, 7'h7F, '0, '0); cyc(); idle_all();
    @(negedge clk);
    check("db.set_wins", 32'(o_irq[0][1]), 32'h1);

    // Cross-port read during write returns old data.
    acc(0, 1'b1, 7'd9, 32'hAAAA0000, 4'hF); cyc(); idle_all();
    acc(1, 1'b0, 7'd9, '0, '0);
    acc(0, 1'b1, 7'd9, 32'h12345678, 4'hF); cyc(); idle_all();
    acc(1, 1'b0, 7'd9, '0, '0);
    @(negedge clk);
    check("xport.old", o_rdata[0][1], 32'hAAAA0000);
    cyc(); idle_all();
    @(negedge clk);
    check("xport.new", o_rdata[0][1], 32'h12345678);

    // Latency-2 stream on s1 with a 2-cycle clken drop.
    for (int i = 0; i < 4; i++) begin
      acc(0, 1'b1, 7'(i), 32'hC0DE0000 + 32'(i), 4'hF); cyc();
    end
    idle_all();
    t_cs = 10'b0000110011;
    t_ce = 10'b1111110011;
    apply_step(0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      apply_step(k + 1);
      @(negedge clk);
      exp_v = (k >= 3 && k <= 6);
      check($sformatf("lat2.s1.valid[%0d]", k), 32'(o_valid[1][0]), 32'(exp_v));
      if (exp_v) check($sformatf("lat2.s1.data[%0d]", k), o_rdata[1][0],
                       32'hC0DE0000 + 32'(k - 3));
      check($sformatf("lat2.s2.valid[%0d]", k), 32'(o_valid[1][1]), 32'(k == 1));
    end
    idle_all();

    // Sentinel word kept clear of later traffic.
    acc(0, 1'b1, 7'd20, 32'h5A5A1234, 4'hF); cyc(); idle_all();

    // Collision counter saturation.
    for (int n = 0; n < 65540; n++) begin
      acc(0, 1'b1, 7'd10, $urandom, 4'($urandom));
      acc(1, 1'b1, 7'd10, $urandom, 4'($urandom));
      cyc();
    end
    idle_all();
    @(negedge clk);
    check("sat.a", 32'(o_cnt[0]), 32'h0000FFFF);
    check("sat.b", 32'(o_cnt[1]), 32'h0000FFFF);

    // Random traffic on a small address window including the doorbell.
    for (int n = 0; n < 2000; n++) begin
      for (int p = 0; p < 2; p++) begin
        r     = int'($urandom_range(0, 8));
        cs[p] = ($urandom_range(0, 3) != 0);
        ce[p] = ($urandom_range(0, 7) != 0);
        we[p] = $urandom_range(0, 1) == 1;
        ad[p] = (r == 8) ? 7'h7F : 7'(r);
        wd[p] = $urandom;
        be[p] = 4'($urandom);
      end
      cyc();
    end
    idle_all();

    // Reset with reads in flight on both ports.
    acc(0, 1'b0, 7'd20, '0, '0);
    acc(1, 1'b0, 7'd20, '0, '0);
    cyc(); idle_all();
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    n_pulse = 0;
    repeat (6) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        for (int p = 0; p < 2; p++)
          if (o_valid[d][p] === 1'b1) n_pulse++;
    end
    check("rst.no_pulse", 32'(n_pulse), 32'h0);
    check("rst.cnt", 32'(o_cnt[1]), 32'h0);
    check("rst.irq", 32'({o_irq[1][0], o_irq[1][1]}), 32'h0);
    acc(0, 1'b0, 7'd20, '0, '0); cyc(); idle_all();
    @(negedge clk);
    check("rst.keep.valid", 32'(o_valid[0][0]), 32'h1);
    check("rst.keep.data", o_rdata[0][0], 32'h5A5A1234);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
